comb_arb: RTL and testbench
===========================

# comb_arb

Two-requester scheduler for the shared `comb_test` combinational datapath. It round-robin arbitrates operand triples from two clients and registers the winner into the datapath. It captures the five datapath outputs one cycle later and presents them, tagged with the requester id, on a single valid/ready result port. It sits between the two client pipelines and one `comb_test #(SIZE)` instance, so only one evaluation is ever in flight.

## Interface
- `SIZE`, default 4: operand and result width in bits; legal range 1 to 8.
- `clk` input 1: the only clock; all state on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 2: per-requester operand valid, bit i belongs to requester i.
- `req_ready` output 2: per-requester accept; at most one bit is high in any cycle.
- `req0_src1`, `req0_src2`, `req0_src3` input SIZE each: requester 0 operands.
- `req1_src1`, `req1_src2`, `req1_src3` input SIZE each: requester 1 operands.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_id` output 1: requester that owns the presented result.
- `res_out1` … `res_out5` output SIZE each: captured datapath outputs.
- `done_cnt` output 8: count of completed result handshakes; wraps 255→0.

## Operation
- Datapath function, with lsbs = {src3[0], src2[0], src1[0]}:
  - Defaults: out1 = src1, out2 = src2.
  - If src1 < src2 (unsigned): out3 = src2 and out5 = src3.
    - lsbs = 1: out1 = out2 = out4 = src3.
    - lsbs = 3: out3 = 0, out4 = 0.
    - Otherwise: out4 = src1.
  - Else: out3 = src1, out4 = src2, out5 = src1.
- FSM states are IDLE, EVAL and HOLD.
  - IDLE: can accept. On a handshake, register the winner's operands and id, then go to EVAL.
  - EVAL: `req_ready` = 0. Capture the `comb_test` outputs into the result registers, set `res_valid`, go to HOLD.
  - HOLD: `res_valid` = 1 and all result fields stay stable until `res_ready`.
    - If `res_ready` and a request is pending: accept it in the same cycle and go to EVAL.
    - If `res_ready` and no request is pending: go to IDLE.
    - If `res_ready` = 0: stay in HOLD with `req_ready` = 0.
- Accept condition is state == IDLE, or state == HOLD with `res_ready` = 1.
- Arbitration:
  - A 1-bit priority pointer selects the favoured requester.
  - If both requesters are valid, the favoured one wins. If only one is valid, it wins.
  - After each grant the pointer moves to the other requester. The pointer changes only on a handshake.
- `req_ready[i]` = accept condition AND grant[i]. Requesters hold valid and payload stable until ready; withdrawal is illegal and is not checked.
- `done_cnt` increments on every `res_valid` & `res_ready` cycle and wraps modulo 256.

## Timing
- Reset values: state = IDLE, pointer favours requester 0, `req_ready` = 0 during reset, `res_valid` = 0, `res_id` = 0, `res_out1` … `res_out5` = 0, `done_cnt` = 0. Operand registers also reset to 0.
- Latency: a request handshake in cycle N gives `res_valid` high in cycle N+2.
- Throughput:
  - One result per 2 cycles when `res_ready` is held high and requests are continuous.
  - The result handshake and the next request handshake may fall in the same cycle.
- Idle `req_ready`: in IDLE with no request valid, `req_ready` = 0 (the grant is 0).
- Reset asserted mid-operation immediately discards the in-flight operands and any held result. No result is emitted for them.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, state, pointer and `res_ready`.

## Structure
- Package `comb_arb_pkg` holds:
  - the state enum `comb_arb_state_t` {IDLE, EVAL, HOLD};
  - the constant `COMB_ARB_NREQ` = 2;
  - the counter width constant (8).
- Sub-module `comb_arb_rr`: a 2-way round-robin grant generator. Inputs: valid vector, pointer, enable. Outputs: one-hot grant and next pointer.
- Exactly one `comb_test #(SIZE)` instance is driven by the operand registers.

## Test plan
- Single request, SIZE = 4:
  - Stimulus: requester 0 sends src1 = 2, src2 = 5, src3 = 8; `res_ready` held high.
  - Response: `res_valid` at handshake+2 with id 0, outputs 2, 5, 5, 2, 8.
- lsbs = 1 case:
  - Stimulus: requester 1 sends src1 = 3, src2 = 4, src3 = 6.
  - Response: id 1, outputs 6, 6, 4, 6, 6.
- lsbs = 3 case and else branch:
  - Stimulus: send 3, 5, 2, then 7, 3, 1.
  - Response: first result 3, 5, 0, 0, 2; second result 7, 3, 7, 3, 7.
- Contention:
  - Stimulus: both requesters valid continuously after reset; `res_ready` = 1.
  - Response: `res_id` sequence is 0, 1, 0, 1; one result every 2 cycles; `req_ready` never has both bits set.
- Backpressure:
  - Stimulus: hold `res_ready` = 0 for 5 cycles while in HOLD.
  - Response: result fields stable, `req_ready` = 0 throughout. When `res_ready` rises, the pending request is accepted in that same cycle.
- Reset and counter:
  - Stimulus: assert `rst_n` low while in EVAL.
  - Response: `res_valid` = 0 with no spurious result afterwards.
  - Stimulus: complete 256 results.
  - Response: `done_cnt` wraps to 0.

Source files
------------

// File: rtl/comb_arb_pkg.sv
// Shared types and constants for the two-requester comb_test scheduler.
package comb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    HOLD
  } comb_arb_state_t;

  localparam int COMB_ARB_NREQ  = 2;
  localparam int COMB_ARB_CNT_W = 8;

endpackage

// File: rtl/comb_arb_if.sv
// Request/result bundle between the client pipelines, the scheduler and the consumer.
interface comb_arb_if #(
  parameter int SIZE = 4
);

  logic [comb_arb_pkg::COMB_ARB_NREQ-1:0]  req_valid;
  logic [comb_arb_pkg::COMB_ARB_NREQ-1:0]  req_ready;
  logic [SIZE-1:0]                         req0_src1, req0_src2, req0_src3;
  logic [SIZE-1:0]                         req1_src1, req1_src2, req1_src3;
  logic                                    res_valid;
  logic                                    res_ready;
  logic                                    res_id;
  logic [SIZE-1:0]                         res_out1, res_out2, res_out3, res_out4, res_out5;
  logic [comb_arb_pkg::COMB_ARB_CNT_W-1:0] done_cnt;

  modport slave (
    input  req_valid, req0_src1, req0_src2, req0_src3,
           req1_src1, req1_src2, req1_src3, res_ready,
    output req_ready, res_valid, res_id,
           res_out1, res_out2, res_out3, res_out4, res_out5, done_cnt
  );

  modport master (
    output req_valid, req0_src1, req0_src2, req0_src3,
           req1_src1, req1_src2, req1_src3, res_ready,
    input  req_ready, res_valid, res_id,
           res_out1, res_out2, res_out3, res_out4, res_out5, done_cnt
  );

endinterface

// File: rtl/comb_arb_rr.sv
// Two-way round-robin grant: the pointer picks the winner only when both requesters are valid.
module comb_arb_rr
  import comb_arb_pkg::*;
(
  input  logic [COMB_ARB_NREQ-1:0] valid,
  input  logic                     ptr,
  input  logic                     en,
  output logic [COMB_ARB_NREQ-1:0] grant,
  output logic                     next_ptr
);

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    if (en) begin
      if (&valid) grant[ptr] = 1'b1;
      else        grant      = valid;
      // After a grant the other requester is favoured.
      if (|grant) next_ptr = !grant[1];
    end
  end

endmodule

// File: rtl/comb_test.sv
// Shared combinational datapath: compare/select over three operands.
module comb_test #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] src1,
  input  logic [SIZE-1:0] src2,
  input  logic [SIZE-1:0] src3,
  output logic [SIZE-1:0] out1,
  output logic [SIZE-1:0] out2,
  output logic [SIZE-1:0] out3,
  output logic [SIZE-1:0] out4,
  output logic [SIZE-1:0] out5
);

  logic [2:0] lsbs;
  assign lsbs = {src3[0], src2[0], src1[0]};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    out1 = src1;
    out2 = src2;
    out3 = src1;
    out4 = src2;
    out5 = src1;
    if (src1 < src2) begin
      out3 = src2;
      out5 = src3;
      case (lsbs)
        3'd1: begin
          out1 = src3;
          out2 = src3;
          out4 = src3;
        end
        3'd3: begin
          out3 = '0;
          out4 = '0;
        end
        default: out4 = src1;
      endcase
    end
  end

endmodule

// File: rtl/comb_arb.sv
// Round-robin scheduler feeding one comb_test instance, with a registered valid/ready result port.
module comb_arb
  import comb_arb_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  comb_arb_if.slave  bus
);

  comb_arb_state_t            state;
  logic                       ptr, next_ptr;
  logic                       accept, hs;
  logic [COMB_ARB_NREQ-1:0]   grant;
  logic [SIZE-1:0]            op1, op2, op3;
  logic                       op_id;
  logic [SIZE-1:0]            d1, d2, d3, d4, d5;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign accept        = rst_n && (state == IDLE || (state == HOLD && bus.res_ready));
  assign hs            = |grant;
  assign bus.req_ready = grant;

  comb_arb_rr u_rr (
    .valid    (bus.req_valid),
    .ptr      (ptr),
    .en       (accept),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  comb_test #(.SIZE(SIZE)) u_dp (
    .src1 (op1),
    .src2 (op2),
    .src3 (op3),
    .out1 (d1),
    .out2 (d2),
    .out3 (d3),
    .out4 (d4),
    .out5 (d5)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      op1          <= '0;
      op2          <= '0;
      op3          <= '0;
      op_id        <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.res_out1  <= '0;
      bus.res_out2  <= '0;
      bus.res_out3  <= '0;
      bus.res_out4  <= '0;
      bus.res_out5  <= '0;
      bus.done_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ptr <= next_ptr;
      if (hs) begin
        op1   <= grant[1] ? bus.req1_src1 : bus.req0_src1;
        op2   <= grant[1] ? bus.req1_src2 : bus.req0_src2;
        op3   <= grant[1] ? bus.req1_src3 : bus.req0_src3;
        op_id <= grant[1];
      end
      case (state)
        IDLE: if (hs) state <= EVAL;
        EVAL: begin
          bus.res_out1  <= d1;
          bus.res_out2  <= d2;
          bus.res_out3  <= d3;
          bus.res_out4  <= d4;
          bus.res_out5  <= d5;
          bus.res_id    <= op_id;
          bus.res_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          bus.done_cnt  <= bus.done_cnt + 1'b1;
          state         <= hs ? EVAL : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_arb.sv
// Scoreboard bench for comb_arb: directed vectors push expected results, a monitor pops and compares.
module tb_comb_arb;

  localparam int SIZE = 4;

  typedef struct packed {
    logic            id;
    logic [SIZE-1:0] o1, o2, o3, o4, o5;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_done = 0;
  exp_t sb[$];

  comb_arb_if #(.SIZE(SIZE)) bus ();

  comb_arb #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic id, input int a, input int b, input int c,
                              input int d, input int e);
    exp_t r;
    r.id = id;
    r.o1 = SIZE'(a);
    r.o2 = SIZE'(b);
    r.o3 = SIZE'(c);
    r.o4 = SIZE'(d);
    r.o5 = SIZE'(e);
    return r;
  endfunction

  task automatic present(input int id, input int a, input int b, input int c, input exp_t e);
    if (id == 0) begin
      bus.req0_src1 = SIZE'(a);
      bus.req0_src2 = SIZE'(b);
      bus.req0_src3 = SIZE'(c);
    end else begin
      bus.req1_src1 = SIZE'(a);
      bus.req1_src2 = SIZE'(b);
      bus.req1_src3 = SIZE'(c);
    end
    bus.req_valid[id] = 1'b1;
    sb.push_back(e);
    #1;
  endtask

  task automatic wait_hs(input int id);
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready[id]) break;
      @(negedge clk);
      #1;
    end
    check($sformatf("req%0d_handshake", id), 32'(bus.req_ready[id]), 1);
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every result handshake, checks HOLD stability and grant exclusivity.
  logic stall = 1'b0;
  logic [5*SIZE:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall    = 1'b0;
      exp_done = 0;
    end else begin
      check("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      if (stall)
        check("hold_stable", 32'({bus.res_id, bus.res_out1, bus.res_out2, bus.res_out3,
                                  bus.res_out4, bus.res_out5}), 32'(held));
      if (bus.res_valid && !bus.res_ready) begin
        check("hold_req_ready", 32'(bus.req_ready), 0);
        stall = 1'b1;
        held  = {bus.res_id, bus.res_out1, bus.res_out2, bus.res_out3, bus.res_out4, bus.res_out5};
      end else begin
        stall = 1'b0;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_id", 32'(bus.res_id), 32'(e.id));
          check("res_outs", 32'({bus.res_out1, bus.res_out2, bus.res_out3, bus.res_out4,
                                 bus.res_out5}), 32'({e.o1, e.o2, e.o3, e.o4, e.o5}));
        end
        exp_done++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hs;
    int last_cyc;
    int seen;

    rst_n          = 1'b0;
    bus.res_ready  = 1'b1;
    // Contention payloads: requester 0 -> 2,5,8 ; requester 1 -> 3,4,6 (lsbs = 1).
    bus.req0_src1  = 4'd2; bus.req0_src2 = 4'd5; bus.req0_src3 = 4'd8;
    bus.req1_src1  = 4'd3; bus.req1_src2 = 4'd4; bus.req1_src3 = 4'd6;
    bus.req_valid  = 2'b11;

    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    check("rst_res_outs", 32'({bus.res_out1, bus.res_out2, bus.res_out3, bus.res_out4,
                               bus.res_out5}), 0);
    check("rst_done_cnt", 32'(bus.done_cnt), 0);

    // Contention straight out of reset: grants alternate 0,1,0,1 every 2 cycles.
    for (int k = 0; k < 4; k++)
      sb.push_back((k % 2 == 0) ? mk(0, 2, 5, 5, 2, 8) : mk(1, 6, 6, 4, 6, 6));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_hs     = 0;
    last_cyc = 0;
    for (int i = 0; i < 40 && n_hs < 4; i++) begin
      if (bus.req_ready != 2'b00) begin
        check("contention_grant", 32'(bus.req_ready), (n_hs % 2 == 0) ? 1 : 2);
        if (n_hs > 0) check("contention_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        n_hs++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    check("contention_hs_count", n_hs, 4);
    drain();

    // Single request with latency check: valid appears 2 cycles after the handshake.
    present(0, 2, 5, 8, mk(0, 2, 5, 5, 2, 8));
    wait_hs(0);
    @(negedge clk);
    check("latency_n1_valid", 32'(bus.res_valid), 0);
    @(negedge clk);
    check("latency_n2_valid", 32'(bus.res_valid), 1);
    drain();

    present(1, 3, 4, 6, mk(1, 6, 6, 4, 6, 6));
    wait_hs(1);
    drain();

    present(0, 3, 5, 2, mk(0, 3, 5, 0, 0, 2));
    wait_hs(0);
    present(0, 7, 3, 1, mk(0, 7, 3, 7, 3, 7));
    wait_hs(0);
    drain();
    check("done_cnt_after_directed", 32'(bus.done_cnt), 32'(exp_done % 256));

    // Backpressure: result held 5 cycles, pending requester 1 accepted as res_ready rises.
    bus.res_ready = 1'b0;
    present(0, 2, 5, 8, mk(0, 2, 5, 5, 2, 8));
    wait_hs(0);
    present(1, 3, 5, 2, mk(1, 3, 5, 0, 0, 2));
    check("bp_eval_req_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    check("bp_hold_valid", 32'(bus.res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready_low", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    #1;
    check("bp_same_cycle_accept", 32'(bus.req_ready), 2);
    wait_hs(1);
    drain();

    // Reset during EVAL discards the in-flight request.
    present(0, 7, 3, 1, mk(0, 7, 3, 7, 3, 7));
    wait_hs(0);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_res_valid", 32'(bus.res_valid), 0);
    check("midrst_res_outs", 32'({bus.res_out1, bus.res_out2, bus.res_out3, bus.res_out4,
                                  bus.res_out5}), 0);
    check("midrst_done_cnt", 32'(bus.done_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    check("midrst_no_result", seen, 0);

    // Counter wrap: 255 results then one more.
    for (int i = 0; i < 255; i++) begin
      present(0, 2, 5, 8, mk(0, 2, 5, 5, 2, 8));
      wait_hs(0);
    end
    drain();
    check("done_cnt_255", 32'(bus.done_cnt), 255);
    present(0, 2, 5, 8, mk(0, 2, 5, 5, 2, 8));
    wait_hs(0);
    drain();
    check("done_cnt_wrap", 32'(bus.done_cnt), 0);
    check("done_cnt_model", 32'(bus.done_cnt), 32'(exp_done % 256));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
